// File: rtl/vdic_arg_collector.sv
// rtl/vdic_arg_collector.sv - VDIC operand/command collector with parity check and operand replay
module vdic_arg_collector #(
    parameter int DATA_W   = 8,
    parameter int MAX_ARGS = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_ctl,
    input  logic              in_parity,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_cmd,
    output logic [DATA_W-1:0] op_arg,
    output logic              op_first,
    output logic              op_last,
    output logic              sts_valid,
    output logic [7:0]        sts_code
);

    localparam int CNT_W = $clog2(MAX_ARGS + 1);

    // Status bit encoding shared with the rest of the datapath
    localparam logic [7:0] STS_BAD_CMD  = 8'h80;
    localparam logic [7:0] STS_CMD_PAR  = 8'h40;
    localparam logic [7:0] STS_DATA_PAR = 8'h20;
    localparam logic [7:0] STS_OVF      = 8'h02;
    localparam logic [7:0] STS_ARGS     = 8'h01;

    typedef enum logic {
        COLLECT = 1'b0,
        ISSUE   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               ovf_q, ovf_d;
    logic               dpar_q, dpar_d;
    logic               in_ready_q, in_ready_d;
    logic [DATA_W-1:0]  cmd_q, cmd_d;
    logic               sts_valid_q, sts_valid_d;
    logic [7:0]         sts_code_q, sts_code_d;
    logic [DATA_W-1:0]  stack_q [MAX_ARGS];
    logic [DATA_W-1:0]  stack_d [MAX_ARGS];

    logic               parity_ok;
    logic               cmd_known;
    logic               cmd_is_nop;
    logic               in_fire;
    logic               beat_last;
    logic [7:0]         status;

    assign parity_ok  = ~^{in_parity, in_ctl, in_data};
    assign in_fire    = in_valid & in_ready_q;
    assign cmd_is_nop = (in_data == '0);
    assign beat_last  = (idx_q == count_q - CNT_W'(1));

    // Command code whitelist: NOP plus the five arithmetic operations
    always_comb begin
        cmd_known = 1'b0;
        if (in_data == DATA_W'(8'h00) || in_data == DATA_W'(8'h01) ||
            in_data == DATA_W'(8'h02) || in_data == DATA_W'(8'h03) ||
            in_data == DATA_W'(8'h10) || in_data == DATA_W'(8'h20)) begin
            cmd_known = 1'b1;
        end
    end

    // Frame status: a bad command parity masks the code-dependent checks
    always_comb begin
        status = 8'h00;
        if (!parity_ok) begin
            status = status | STS_CMD_PAR;
        end else if (!cmd_known) begin
            status = status | STS_BAD_CMD;
        end else if (!cmd_is_nop && count_q < CNT_W'(2)) begin
            status = status | STS_ARGS;
        end
        if (ovf_q) begin
            status = status | STS_OVF;
        end
        if (dpar_q) begin
            status = status | STS_DATA_PAR;
        end
    end

    // Next-state logic: stack operands, judge the command, replay beats
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        ovf_d       = ovf_q;
        dpar_d      = dpar_q;
        cmd_d       = cmd_q;
        stack_d     = stack_q;
        sts_valid_d = 1'b0;
        sts_code_d  = 8'h00;

        case (state_q)
            COLLECT: begin
                if (in_fire) begin
                    if (!in_ctl) begin
                        if (!parity_ok) begin
                            dpar_d = 1'b1;
                        end else if (count_q == CNT_W'(MAX_ARGS)) begin
                            ovf_d = 1'b1;
                        end else begin
                            stack_d[count_q] = in_data;
                            count_d          = count_q + CNT_W'(1);
                        end
                    end else if (status != 8'h00 || cmd_is_nop) begin
                        sts_valid_d = (status != 8'h00);
                        sts_code_d  = status;
                        count_d     = '0;
                        ovf_d       = 1'b0;
                        dpar_d      = 1'b0;
                        for (int i = 0; i < MAX_ARGS; i++) begin
                            stack_d[i] = '0;
                        end
                    end else begin
                        cmd_d   = in_data;
                        idx_d   = '0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (op_ready) begin
                    if (beat_last) begin
                        count_d = '0;
                        ovf_d   = 1'b0;
                        dpar_d  = 1'b0;
                        state_d = COLLECT;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase

        in_ready_d = (state_d == COLLECT);
    end

    // State and datapath registers; in_ready stays low until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            count_q     <= '0;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
            dpar_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            cmd_q       <= '0;
            sts_valid_q <= 1'b0;
            sts_code_q  <= 8'h00;
            for (int i = 0; i < MAX_ARGS; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_d;
            dpar_q      <= dpar_d;
            in_ready_q  <= in_ready_d;
            cmd_q       <= cmd_d;
            sts_valid_q <= sts_valid_d;
            sts_code_q  <= sts_code_d;
            stack_q     <= stack_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign op_valid  = (state_q == ISSUE);
    assign op_cmd    = cmd_q;
    assign op_arg    = (state_q == ISSUE) ? stack_q[idx_q] : '0;
    assign op_first  = (state_q == ISSUE) && (idx_q == '0);
    assign op_last   = (state_q == ISSUE) && beat_last;
    assign sts_valid = sts_valid_q;
    assign sts_code  = sts_code_q;

endmodule

// File: tb/tb_vdic_arg_collector.sv
// tb/tb_vdic_arg_collector.sv - self-checking bench for vdic_arg_collector
module tb_vdic_arg_collector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_ctl = 1'b0;
    logic       in_parity = 1'b0;
    logic       op_valid;
    logic       op_ready = 1'b0;
    logic [7:0] op_cmd;
    logic [7:0] op_arg;
    logic       op_first;
    logic       op_last;
    logic       sts_valid;
    logic [7:0] sts_code;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: frame operands as a queue, flags, replay position
    int       m_args[$];
    bit       m_started, m_busy, m_ovf, m_dpar, m_fire;
    int       m_idx;
    bit [7:0] m_cmd, m_sts;

    // Observation logs for literal checks
    int b_arg[$];
    int b_first[$];
    int b_last[$];
    int s_log[$];
    int vcycles;

    vdic_arg_collector #(.DATA_W(8), .MAX_ARGS(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_ctl(in_ctl), .in_parity(in_parity),
        .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd),
        .op_arg(op_arg), .op_first(op_first), .op_last(op_last),
        .sts_valid(sts_valid), .sts_code(sts_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit known_code(input bit [7:0] c);
        return c inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h20};
    endfunction

    task automatic model_reset();
        m_args.delete();
        m_started = 0; m_busy = 0; m_ovf = 0; m_dpar = 0;
        m_idx = 0; m_cmd = 8'h00; m_sts = 8'h00; m_fire = 0;
    endtask

    task automatic model_clear();
        m_args.delete();
        m_ovf = 0;
        m_dpar = 0;
    endtask

    // Advance the model across one rising edge given the inputs now driven
    task automatic model_step(input bit v, input bit [7:0] d, input bit ctl, input bit good, input bit ordy);
        bit [7:0] st;
        bit [7:0] new_sts;
        new_sts = 8'h00;
        m_fire = 0;
        if (m_busy) begin
            if (ordy) begin
                if (m_idx == m_args.size() - 1) begin
                    m_busy = 0;
                    model_clear();
                end else begin
                    m_idx++;
                end
            end
        end else if (m_started && v) begin
            m_fire = 1;
            if (!ctl) begin
                if (!good) m_dpar = 1;
                else if (m_args.size() < 9) m_args.push_back(int'(d));
                else m_ovf = 1;
            end else begin
                st = 8'h00;
                if (!good) st |= 8'h40;
                else if (!known_code(d)) st |= 8'h80;
                else if (d != 8'h00 && m_args.size() < 2) st |= 8'h01;
                if (m_ovf) st |= 8'h02;
                if (m_dpar) st |= 8'h20;
                if (st != 0) begin
                    new_sts = st;
                    model_clear();
                end else if (d == 8'h00) begin
                    model_clear();
                end else begin
                    m_cmd = d;
                    m_idx = 0;
                    m_busy = 1;
                end
            end
        end
        m_sts = new_sts;
        m_started = 1;
    endtask

    // One clock: compare outputs against the model, drive new inputs, log, advance model
    task automatic cycle(input bit v, input bit [7:0] d, input bit ctl, input bit good, input bit ordy);
        @(negedge clk);
        chk("in_ready", in_ready, m_started && !m_busy);
        chk("op_valid", op_valid, m_busy);
        chk("op_cmd", op_cmd, m_cmd);
        if (m_busy) begin
            chk("op_arg", op_arg, m_args[m_idx]);
            chk("op_first", op_first, m_idx == 0);
            chk("op_last", op_last, m_idx == m_args.size() - 1);
        end
        chk("sts_valid", sts_valid, m_sts != 0);
        if (m_sts != 0) chk("sts_code", sts_code, m_sts);
        in_valid  = v;
        in_data   = d;
        in_ctl    = ctl;
        in_parity = (^{ctl, d}) ^ !good;
        op_ready  = ordy;
        if (op_valid) vcycles++;
        if (op_valid && ordy) begin
            b_arg.push_back(int'(op_arg));
            b_first.push_back(int'(op_first));
            b_last.push_back(int'(op_last));
        end
        if (sts_valid) s_log.push_back(int'(sts_code));
        model_step(v, d, ctl, good, ordy);
    endtask

    task automatic send(input bit [7:0] d, input bit ctl, input bit good);
        bit done;
        done = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            cycle(1, d, ctl, good, 1);
            done = m_fire;
        end
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 8'h00, 0, 1, 1);
    endtask

    task automatic clear_logs();
        b_arg.delete(); b_first.delete(); b_last.delete(); s_log.delete();
        vcycles = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 0; in_ctl = 0; in_data = 0; in_parity = 0; op_ready = 0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_cmd", op_cmd, 0);
        chk("rst_op_arg", op_arg, 0);
        chk("rst_op_first", op_first, 0);
        chk("rst_op_last", op_last, 0);
        chk("rst_sts_valid", sts_valid, 0);
        chk("rst_sts_code", sts_code, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", in_ready, 0);
        m_started = 1;
        clear_logs();
    endtask

    initial begin
        bit [7:0] codes [8];
        bit [7:0] d;
        bit ctl;
        model_reset();
        clear_logs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_in_ready_low", in_ready, 0);
        m_started = 1;
        idle(2);

        // Reset in the middle of operand replay aborts the frame
        send(8'h05, 0, 1); send(8'h03, 0, 1); send(8'h10, 1, 1);
        cycle(0, 8'h00, 0, 1, 0);
        do_reset();
        idle(4);
        chk("t1_no_beats", b_arg.size(), 0);

        // Two-operand frame replayed in arrival order
        clear_logs();
        send(8'h05, 0, 1); send(8'h03, 0, 1); send(8'h10, 1, 1);
        idle(5);
        chk("t2_nbeats", b_arg.size(), 2);
        if (b_arg.size() == 2) begin
            chk("t2_arg0", b_arg[0], 8'h05);
            chk("t2_first0", b_first[0], 1);
            chk("t2_last0", b_last[0], 0);
            chk("t2_arg1", b_arg[1], 8'h03);
            chk("t2_last1", b_last[1], 1);
        end
        chk("t2_cmd", op_cmd, 8'h10);
        chk("t2_no_sts", s_log.size(), 0);

        // Backpressure holds the first beat
        clear_logs();
        send(8'h0F, 0, 1); send(8'hF0, 0, 1); send(8'h20, 1, 1);
        vcycles = 0;
        repeat (3) cycle(0, 8'h00, 0, 1, 0);
        idle(4);
        chk("t3_vcycles", vcycles, 5);
        chk("t3_nbeats", b_arg.size(), 2);
        if (b_arg.size() == 2) begin
            chk("t3_arg0", b_arg[0], 8'h0F);
            chk("t3_arg1", b_arg[1], 8'hF0);
        end

        // Overflow at ten operands; exactly nine is legal
        clear_logs();
        for (int i = 0; i < 10; i++) send(8'(i + 1), 0, 1);
        send(8'h01, 1, 1);
        idle(3);
        chk("t4_ovf_nsts", s_log.size(), 1);
        if (s_log.size() == 1) chk("t4_ovf_code", s_log[0], 8'h02);
        chk("t4_ovf_nbeats", b_arg.size(), 0);
        clear_logs();
        for (int i = 0; i < 9; i++) send(8'(8'h30 + i), 0, 1);
        send(8'h01, 1, 1);
        idle(12);
        chk("t4_full_nbeats", b_arg.size(), 9);
        if (b_arg.size() == 9) begin
            chk("t4_full_arg8", b_arg[8], 8'h38);
            chk("t4_full_last8", b_last[8], 1);
        end

        // Status encodings
        clear_logs();
        send(8'h44, 0, 0); send(8'h01, 0, 1); send(8'h02, 1, 1);
        idle(2);
        send(8'h01, 0, 1); send(8'h02, 0, 1); send(8'h07, 1, 1);
        idle(2);
        send(8'h10, 1, 0);
        idle(2);
        chk("t5_nsts", s_log.size(), 3);
        if (s_log.size() == 3) begin
            chk("t5_sts0", s_log[0], 8'h21);
            chk("t5_sts1", s_log[1], 8'h80);
            chk("t5_sts2", s_log[2], 8'h40);
        end
        chk("t5_nbeats", b_arg.size(), 0);

        // NOP discards the frame silently; next frame is clean
        clear_logs();
        send(8'h11, 0, 1); send(8'h22, 0, 1); send(8'h00, 1, 1);
        idle(3);
        chk("t6_nop_beats", b_arg.size(), 0);
        chk("t6_nop_sts", s_log.size(), 0);
        send(8'h01, 0, 1); send(8'h02, 0, 1); send(8'h03, 1, 1);
        idle(5);
        chk("t6_nbeats", b_arg.size(), 2);

        // Randomized traffic against the model
        codes[0] = 8'h00; codes[1] = 8'h01; codes[2] = 8'h02; codes[3] = 8'h03;
        codes[4] = 8'h10; codes[5] = 8'h20; codes[6] = 8'h07; codes[7] = 8'hFF;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                ctl = ($urandom_range(0, 7) == 0);
                d = ctl ? codes[$urandom_range(0, 7)] : 8'($urandom);
                cycle($urandom_range(0, 3) != 0, d, ctl, $urandom_range(0, 15) != 0,
                      $urandom_range(0, 3) != 0);
            end
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
